drum_audio_streamer: RTL and testbench

- Sits downstream of the per-row drum column solver and consumes its u(n+1) row stream.
- Each time step, captures the amplitude of one selected tap row and converts it from signed 1.17 to 16-bit audio.
- Buffers samples in a small FIFO and presents them to the audio-codec interface via a valid/ready handshake.
- Decouples the fast solver rate from the codec's pull rate; drops and counts samples on overflow.

---
 rtl/drum_audio_streamer.sv | 123 ++++++++++++
 tb/tb_drum_audio_streamer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_audio_streamer.sv
// Captures one tap row of the drum solver stream per time step, converts 1.17 to
// 16-bit audio and streams it to the codec through a small FIFO with overflow drop.
module drum_audio_streamer #(
   parameter int unsigned DATA_W     = 18,
   parameter int unsigned ROW_W      = 6,
   parameter int unsigned AUDIO_W    = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sim_valid,
   input  logic [ROW_W-1:0]              sim_row,
   input  logic [DATA_W-1:0]             sim_data,
   input  logic [ROW_W-1:0]              tap_row,
   input  logic [1:0]                    gain_shift,
   input  logic                          stream_en,
   output logic                          aud_valid,
   output logic [AUDIO_W-1:0]            aud_data,
   input  logic                          aud_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              drop_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned EXT_W = DATA_W + 3;

   logic                   conv_valid_q, conv_valid_d;
   logic [AUDIO_W-1:0]     conv_data_q, conv_data_d;
   logic [AUDIO_W-1:0]     mem_q [FIFO_DEPTH];
   logic [AUDIO_W-1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   aud_valid_q, aud_valid_d;
   logic [AUDIO_W-1:0]     aud_data_q, aud_data_d;
   logic [CNT_W-1:0]       drop_q, drop_d;

   logic signed [EXT_W-1:0]  ext;
   logic signed [EXT_W-1:0]  shifted;
   logic signed [DATA_W-1:0] clamped;
   logic [AUDIO_W-1:0]       conv_sample;
   logic                     capture, full, pop, wr, drop;

   // Gain, saturate to the 1.17 range, then keep the top AUDIO_W bits (truncate).
   always_comb begin
      ext     = {{3{sim_data[DATA_W-1]}}, sim_data};
      shifted = ext <<< gain_shift;
      if ((shifted[EXT_W-1:DATA_W-1] == '0) || (shifted[EXT_W-1:DATA_W-1] == '1)) begin
         clamped = shifted[DATA_W-1:0];
      end else if (shifted[EXT_W-1]) begin
         clamped = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         clamped = {1'b0, {(DATA_W-1){1'b1}}};
      end
      conv_sample = AUDIO_W'(clamped >>> (DATA_W - AUDIO_W));
   end

   always_comb begin
      capture      = sim_valid && stream_en && (sim_row == tap_row);
      full         = (level_q == LVL_W'(FIFO_DEPTH));
      pop          = (level_q != '0) && (!aud_valid_q || aud_ready);
      wr           = conv_valid_q && (!full || pop);
      drop         = conv_valid_q && full && !pop;

      conv_valid_d = capture;
      conv_data_d  = capture ? conv_sample : conv_data_q;

      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q + LVL_W'(wr) - LVL_W'(pop);
      aud_valid_d  = aud_valid_q;
      aud_data_d   = aud_data_q;
      drop_d       = drop_q;

      if (wr) begin
         mem_d[wr_ptr_q] = conv_data_q;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
         aud_valid_d = 1'b1;
         aud_data_d  = mem_q[rd_ptr_q];
      end else if (aud_valid_q && aud_ready) begin
         aud_valid_d = 1'b0;
      end
      if (drop && (drop_q != '1)) begin
         drop_d = drop_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conv_valid_q <= 1'b0;
         conv_data_q  <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         aud_valid_q  <= 1'b0;
         aud_data_q   <= '0;
         drop_q       <= '0;
      end else begin
         conv_valid_q <= conv_valid_d;
         conv_data_q  <= conv_data_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         aud_valid_q  <= aud_valid_d;
         aud_data_q   <= aud_data_d;
         drop_q       <= drop_d;
      end
   end

   assign aud_valid  = aud_valid_q;
   assign aud_data   = aud_data_q;
   assign fifo_level = level_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_drum_audio_streamer.sv
// Directed bench for drum_audio_streamer with a queue-based reference model
// compared every cycle, plus hand-computed literal checks.
module tb_drum_audio_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sim_valid = 1'b0;
   logic [5:0]  sim_row = '0;
   logic [17:0] sim_data = '0;
   logic [5:0]  tap_row = 6'd16;
   logic [1:0]  gain_shift = '0;
   logic        stream_en = 1'b1;
   logic        aud_ready = 1'b1;

   logic        aud_valid, aud_valid2;
   logic [15:0] aud_data, aud_data2;
   logic [3:0]  fifo_level, fifo_level2;
   logic [15:0] drop_cnt;
   logic [3:0]  drop_cnt2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   drum_audio_streamer dut (
      .clk(clk), .rst(rst), .sim_valid(sim_valid), .sim_row(sim_row), .sim_data(sim_data),
      .tap_row(tap_row), .gain_shift(gain_shift), .stream_en(stream_en),
      .aud_valid(aud_valid), .aud_data(aud_data), .aud_ready(aud_ready),
      .fifo_level(fifo_level), .drop_cnt(drop_cnt)
   );

   drum_audio_streamer #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .sim_valid(sim_valid), .sim_row(sim_row), .sim_data(sim_data),
      .tap_row(tap_row), .gain_shift(gain_shift), .stream_en(stream_en),
      .aud_valid(aud_valid2), .aud_data(aud_data2), .aud_ready(aud_ready),
      .fifo_level(fifo_level2), .drop_cnt(drop_cnt2)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference conversion from the numeric definition: scale, saturate, divide by 4 (floor).
   function automatic logic [15:0] convert(input logic [17:0] d, input logic [1:0] g);
      int v;
      v = int'($signed(d));
      v = v * (1 << g);
      if (v > 131071) v = 131071;
      if (v < -131072) v = -131072;
      v = v >>> 2;
      return 16'(v);
   endfunction

   // Model state: capture stage, sample queue, output slot, unbounded drop count.
   bit          m_cv = 1'b0;
   logic [15:0] m_conv = '0;
   logic [15:0] m_q[$];
   bit          m_ov = 1'b0;
   logic [15:0] m_od = '0;
   int          m_drops = 0;
   bit          m_pop;
   int          m_sz;

   int          xfer_cnt = 0;
   logic [15:0] seen[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cv = 1'b0; m_q.delete(); m_ov = 1'b0; m_od = '0; m_drops = 0;
      end else begin
         if (aud_valid && aud_ready) begin
            xfer_cnt++;
            seen.push_back(aud_data);
         end
         m_sz  = m_q.size();
         m_pop = (m_sz > 0) && (!m_ov || aud_ready);
         if (m_pop) begin
            m_od = m_q.pop_front();
            m_ov = 1'b1;
         end else if (m_ov && aud_ready) begin
            m_ov = 1'b0;
         end
         if (m_cv) begin
            if (m_sz == 8 && !m_pop) m_drops++;
            else m_q.push_back(m_conv);
         end
         m_cv = sim_valid && stream_en && (sim_row == tap_row);
         if (m_cv) m_conv = convert(sim_data, gain_shift);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("valid", int'(aud_valid), int'(m_ov));
         if (m_ov) check("data", int'(aud_data), int'(m_od));
         check("level", int'(fifo_level), m_q.size());
         check("drops", int'(drop_cnt), (m_drops > 65535) ? 65535 : m_drops);
         check("valid_sat", int'(aud_valid2), int'(m_ov));
         check("level_sat", int'(fifo_level2), m_q.size());
         check("drops_sat", int'(drop_cnt2), (m_drops > 15) ? 15 : m_drops);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cap(input logic [17:0] d, input logic [1:0] g);
      sim_valid  = 1'b1;
      sim_row    = 6'd16;
      sim_data   = d;
      gain_shift = g;
      tick();
      sim_valid  = 1'b0;
   endtask

   task automatic capture_one(input logic [17:0] d, input logic [1:0] g, input logic [15:0] exp);
      cap(d, g);
      check("lat_e1", int'(aud_valid), 0);
      tick();
      check("lat_e2", int'(aud_valid), 0);
      tick();
      check("conv_valid", int'(aud_valid), 1);
      check("conv_data", int'(aud_data), int'(exp));
      tick();
      gain_shift = '0;
   endtask

   int xfer0;

   initial begin
      #2 rst = 1'b0;
      #1;
      check("rst_valid", int'(aud_valid), 0);
      check("rst_data", int'(aud_data), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_drop", int'(drop_cnt), 0);
      #9 rst = 1'b1;
      tick();

      // Basic sweep: only row 16 is captured
      xfer_cnt = 0;
      for (int r = 0; r <= 32; r++) begin
         sim_valid = 1'b1;
         sim_row   = 6'(r);
         sim_data  = (r == 16) ? 18'h10000 : 18'(r * 32'h1111);
         tick();
         if (r == 16 || r == 17) check("sweep_early", int'(aud_valid), 0);
         if (r == 18) begin
            check("sweep_valid", int'(aud_valid), 1);
            check("sweep_data", int'(aud_data), 16'h4000);
         end
      end
      sim_valid = 1'b0;
      repeat (3) tick();
      check("sweep_xfers", xfer_cnt, 1);

      capture_one(18'h30000, 2'd0, 16'hC000);
      capture_one(18'h10000, 2'd1, 16'h7FFF);
      capture_one(18'h20000, 2'd3, 16'h8000);

      // Backpressure and overflow
      aud_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         sim_valid = 1'b1; sim_row = 6'd16; sim_data = 18'((i + 1) * 32'h400);
         tick();
      end
      sim_valid = 1'b0;
      repeat (3) tick();
      check("bp_level", int'(fifo_level), 8);
      check("bp_drop", int'(drop_cnt), 3);
      check("bp_valid", int'(aud_valid), 1);
      check("bp_data", int'(aud_data), 16'h0100);
      repeat (3) tick();
      check("bp_hold", int'(aud_data), 16'h0100);

      // Full FIFO, pop on the same edge as the write
      cap(18'h03400, 2'd0);
      aud_ready = 1'b1;
      tick();
      aud_ready = 1'b0;
      check("fp_level", int'(fifo_level), 8);
      check("fp_drop", int'(drop_cnt), 3);
      check("fp_data", int'(aud_data), 16'h0200);
      seen.delete();
      aud_ready = 1'b1;
      repeat (12) tick();
      check("drain_cnt", seen.size(), 9);
      if (seen.size() == 9) begin
         check("drain_first", int'(seen[0]), 16'h0200);
         check("drain_second", int'(seen[1]), 16'h0300);
         check("drain_last", int'(seen[8]), 16'h0D00);
      end
      check("drain_valid", int'(aud_valid), 0);

      // stream_en low and non-tap rows are ignored
      xfer0 = xfer_cnt;
      stream_en = 1'b0;
      for (int r = 0; r <= 32; r++) begin
         sim_valid = 1'b1; sim_row = 6'(r); sim_data = 18'h10000;
         tick();
      end
      stream_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sim_valid = 1'b1; sim_row = (i % 2 == 0) ? 6'd15 : 6'd17; sim_data = 18'h10000;
         tick();
      end
      sim_valid = 1'b0;
      repeat (4) tick();
      check("filter_xfers", xfer_cnt, xfer0);
      check("filter_valid", int'(aud_valid), 0);

      // Drop counter saturation (narrow counter instance)
      aud_ready = 1'b0;
      for (int i = 0; i < 25; i++) cap(18'h00800, 2'd0);
      repeat (3) tick();
      check("sat_drop_main", int'(drop_cnt), 19);
      check("sat_drop_narrow", int'(drop_cnt2), 4'hF);
      aud_ready = 1'b1;
      repeat (12) tick();

      // Async reset mid-stream
      aud_ready = 1'b0;
      for (int i = 0; i < 5; i++) cap(18'h01000, 2'd0);
      repeat (3) tick();
      check("pre_rst_level", int'(fifo_level), 4);
      check("pre_rst_valid", int'(aud_valid), 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_valid", int'(aud_valid), 0);
      check("arst_level", int'(fifo_level), 0);
      check("arst_drop", int'(drop_cnt), 0);
      check("arst_drop_narrow", int'(drop_cnt2), 0);
      #2 rst = 1'b1;
      aud_ready = 1'b1;
      tick();
      capture_one(18'h00800, 2'd2, 16'h0800);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
